textmode_char_writer: RTL

Writer side of the 80x60 text-mode character buffer. Accepts a stream of 8-bit character codes over a valid/ready handshake and turns them into single-cell writes on the buffer's write port. Keeps a hardware cursor, interprets a small set of terminal control codes, and fills cells with spaces for row-clear and screen-clear. It is the producer for the buffer that the VGA scan-out path reads and renders through the character ROM.

---
 rtl/textmode_char_writer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/textmode_char_writer.sv
// Writer side of the 80x60 text-mode character buffer: turns a handshaked
// stream of character/control codes into single-cell buffer writes.
module textmode_char_writer #(
  parameter int COLS                = 80,
  parameter int ROWS                = 60,
  parameter int CHARACTER_SET_COUNT = 256
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                char_valid_i,
  input  logic [$clog2(CHARACTER_SET_COUNT)-1:0] char_data_i,
  output logic                                char_ready_o,
  output logic                                wr_en_o,
  output logic [$clog2(COLS*ROWS)-1:0]        wr_addr_o,
  output logic [$clog2(CHARACTER_SET_COUNT)-1:0] wr_data_o,
  output logic [$clog2(COLS)-1:0]             cursor_x_o,
  output logic [$clog2(ROWS)-1:0]             cursor_y_o,
  output logic                                busy_o
);

  localparam int DATA_W = $clog2(CHARACTER_SET_COUNT);
  localparam int ADDR_W = $clog2(COLS*ROWS);
  localparam int X_W    = $clog2(COLS);
  localparam int Y_W    = $clog2(ROWS);
  localparam int CELLS  = COLS*ROWS;

  localparam logic [DATA_W-1:0] CODE_BS    = DATA_W'(8'h08);
  localparam logic [DATA_W-1:0] CODE_LF    = DATA_W'(8'h0A);
  localparam logic [DATA_W-1:0] CODE_FF    = DATA_W'(8'h0C);
  localparam logic [DATA_W-1:0] CODE_CR    = DATA_W'(8'h0D);
  localparam logic [DATA_W-1:0] CODE_SPACE = DATA_W'(8'h20);
  localparam logic [DATA_W-1:0] CODE_DEL   = DATA_W'(8'h7F);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR_ROW,
    CLEAR_ALL
  } state_e;

  state_e              state_q, state_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [ADDR_W-1:0]   clr_base_q, clr_base_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;

  logic                accept;
  logic [ADDR_W-1:0]   cur_addr;
  logic [Y_W-1:0]      y_inc;
  logic [ADDR_W-1:0]   next_row_base;
  logic                printable;

  assign char_ready_o = (state_q == IDLE);
  assign busy_o       = ~char_ready_o;
  assign wr_en_o      = wr_en_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign cursor_x_o   = x_q;
  assign cursor_y_o   = y_q;

  assign accept        = char_valid_i && char_ready_o;
  assign cur_addr      = ADDR_W'(y_q) * ADDR_W'(COLS) + ADDR_W'(x_q);
  assign y_inc         = (y_q == Y_W'(ROWS-1)) ? '0 : y_q + Y_W'(1);
  assign next_row_base = ADDR_W'(y_inc) * ADDR_W'(COLS);
  assign printable     = (char_data_i >= CODE_SPACE) && (char_data_i != CODE_DEL);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      clr_cnt_q  <= '0;
      clr_base_q <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      clr_cnt_q  <= clr_cnt_d;
      clr_base_q <= clr_base_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Entering a new row (wrap or LF) always blanks that row before accepting more input.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    clr_cnt_d  = clr_cnt_q;
    clr_base_d = clr_base_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (char_data_i == CODE_LF) begin
            x_d        = '0;
            y_d        = y_inc;
            clr_base_d = next_row_base;
            clr_cnt_d  = '0;
            state_d    = CLEAR_ROW;
          end else if (char_data_i == CODE_CR) begin
            x_d = '0;
          end else if (char_data_i == CODE_BS) begin
            if (x_q != '0) begin
              x_d       = x_q - X_W'(1);
              wr_en_d   = 1'b1;
              wr_addr_d = cur_addr - ADDR_W'(1);
              wr_data_d = CODE_SPACE;
            end
          end else if (char_data_i == CODE_FF) begin
            x_d       = '0;
            y_d       = '0;
            clr_cnt_d = '0;
            state_d   = CLEAR_ALL;
          end else if (printable) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cur_addr;
            wr_data_d = char_data_i;
            if (x_q == X_W'(COLS-1)) begin
              x_d        = '0;
              y_d        = y_inc;
              clr_base_d = next_row_base;
              clr_cnt_d  = '0;
              state_d    = CLEAR_ROW;
            end else begin
              x_d = x_q + X_W'(1);
            end
          end
        end
      end
      CLEAR_ROW: begin
        wr_en_d   = 1'b1;
        wr_addr_d = clr_base_q + clr_cnt_q;
        wr_data_d = CODE_SPACE;
        if (clr_cnt_q == ADDR_W'(COLS-1)) begin
          state_d = IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end
      end
      CLEAR_ALL: begin
        wr_en_d   = 1'b1;
        wr_addr_d = clr_cnt_q;
        wr_data_d = CODE_SPACE;
        if (clr_cnt_q == ADDR_W'(CELLS-1)) begin
          state_d = IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
